// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Owns the architectural PC and sequences instruction fetch for the
// single-issue core. One fetch is outstanding at a time: the request goes to
// instruction memory over valid/ready, the response comes back valid-only,
// and the fetched word is handed to decode over valid/ready. A redirect from
// the next-PC datapath reloads the PC and kills any stale fetch in flight.
//
// Optional feature macro: FETCH_MISALIGN_CHK_EN
//   defined   : a redirect target with bit 1 set parks the block in a terminal
//               error state (fetch_misalign=1) until reset; the offending
//               target is captured in inst_pc.
//   undefined : no fetch_misalign port; redirect targets are loaded with
//               bits [1:0] cleared.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req_*        fetch request (valid/ready), address always equals PC
//   imem_rsp_*        fetch response (valid-only), 32-bit instruction word
//   inst_valid/ready  handshake to decode; inst/inst_pc held until accepted
//   redirect_*        branch/jump target from the next-PC datapath
//   fetch_cnt         instructions accepted by decode (wraps at 2^64)
//   fetch_misalign    error flag (only with FETCH_MISALIGN_CHK_EN)
// -----------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic        fetch_misalign,
`endif
    output logic [63:0] fetch_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT
`ifdef FETCH_MISALIGN_CHK_EN
        , S_ERR
`endif
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_pc;
    logic        r_kill;
    logic [31:0] r_inst;
    logic [63:0] r_inst_pc;
    logic [63:0] r_fetch_cnt;
    logic [63:0] w_redir_tgt;

`ifdef FETCH_MISALIGN_CHK_EN
    logic        w_err_entry;

    assign w_redir_tgt = redirect_pc;
    // IDLE ignores redirects entirely, and ERR is already terminal.
    assign w_err_entry = redirect_valid && redirect_pc[1]
                         && (r_state != S_IDLE) && (r_state != S_ERR);
`else
    // Word alignment is enforced by masking rather than by checking.
    assign w_redir_tgt = redirect_pc & ~64'd3;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                if (imem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response that is stale (kill) or overtaken by a redirect in
                // the same cycle is dropped and fetch restarts immediately.
                if (imem_rsp_valid) begin
                    w_state_nxt = (redirect_valid || r_kill) ? S_REQ : S_OUT;
                end
            end
            S_OUT: begin
                if (redirect_valid || inst_ready) begin
                    w_state_nxt = S_REQ;
                end
            end
`ifdef FETCH_MISALIGN_CHK_EN
            S_ERR: w_state_nxt = S_ERR;
`endif
            default: w_state_nxt = S_IDLE;
        endcase
`ifdef FETCH_MISALIGN_CHK_EN
        if (w_err_entry) begin
            w_state_nxt = S_ERR;
        end
`endif
    end

    // Output decode: state-only, no input-to-output paths
    always_comb begin
        imem_req_valid = (r_state == S_REQ);
        inst_valid     = (r_state == S_OUT);
`ifdef FETCH_MISALIGN_CHK_EN
        fetch_misalign = (r_state == S_ERR);
`endif
    end

    // PC, kill flag, instruction buffer and consumed-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_kill      <= 1'b0;
            r_inst      <= '0;
            r_inst_pc   <= '0;
            r_fetch_cnt <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (redirect_valid) begin
                        r_pc <= w_redir_tgt;
                        // Request already accepted at this edge: its response
                        // belongs to the old PC and must be thrown away.
                        if (imem_req_ready) begin
                            r_kill <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        r_pc   <= w_redir_tgt;
                        // If the response arrives now it is dropped here and
                        // nothing is left in flight; otherwise the pending one
                        // must be killed when it shows up.
                        r_kill <= !imem_rsp_valid;
                    end else if (imem_rsp_valid) begin
                        if (r_kill) begin
                            r_kill <= 1'b0;
                        end else begin
                            r_inst    <= imem_rsp_data;
                            r_inst_pc <= r_pc;
                        end
                    end
                end
                S_OUT: begin
                    if (inst_ready) begin
                        r_fetch_cnt <= r_fetch_cnt + 64'd1;
                    end
                    if (redirect_valid) begin
                        r_pc <= w_redir_tgt;
                    end else if (inst_ready) begin
                        r_pc <= r_pc + 64'd4;
                    end
                end
                default: ;
            endcase
`ifdef FETCH_MISALIGN_CHK_EN
            if (w_err_entry) begin
                r_inst_pc <= redirect_pc;
            end
`endif
        end
    end

    assign imem_req_addr = r_pc;
    assign inst          = r_inst;
    assign inst_pc       = r_inst_pc;
    assign fetch_cnt     = r_fetch_cnt;

endmodule
